mc_ctrl_fsm: RTL and testbench

Parametrised multicycle control unit for the RV32I multicycle datapath: a Moore state machine plus ALU decoder that sequences fetch, decode, execute, memory and writeback. Successor to the first-generation control unit. It adds sw, R-type, I-type ALU and beq sequencing, an optional jal path, a memory-ready handshake with bounded wait states, and a sticky trap state for illegal opcodes and memory timeouts. It drives every select and enable of the datapath (PC, instruction/data memory, register bank, ALU muxes, result mux).

---
 rtl/mc_pkg.sv | 78 +++++++
 rtl/mc_alu_dec.sv | 31 +++
 rtl/mc_ctrl_fsm.sv | 129 ++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and decode tables for the RV32I multicycle control unit.
// Holds the state encoding, opcode/ALU/immediate codes and the per-state control decode.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Moore part of the control word; fetch is later qualified by mem_ready.
  typedef struct packed {
    logic       fetch;
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    alu_op_t    alu_op;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.fetch = 1'b1; c.src_b = 2'b10; c.result_src = 2'b10; end
      S_DECODE:   begin c.src_a = 2'b01; c.src_b = 2'b01; end
      S_MEMADR:   begin c.src_a = 2'b10; c.src_b = 2'b01; end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      S_EXECR:    begin c.src_a = 2'b10; c.alu_op = ALUOP_FUNCT; end
      S_EXECI:    begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = ALUOP_FUNCT; end
      S_ALUWB:    c.reg_write = 1'b1;
      S_BEQ:      begin c.src_a = 2'b10; c.alu_op = ALUOP_SUB; c.branch = 1'b1; end
      S_JAL:      begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_update = 1'b1; end
      default:    ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU decoder: maps ALUOp plus instruction fields to the 3-bit ALUControl code.
// Purely combinational; unknown funct3 values fall back to add rather than trapping.
import mc_pkg::*;

module mc_alu_dec (
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       op_b5,
  input  logic       funct7_b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op[5] separates R-type sub from addi with imm[10] set
          3'b000:  alu_control = (op_b5 & funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control FSM with mem_ready wait states, bounded timeout and sticky trap.
// Optional jal sequencing compiled in with MC_CTRL_JAL_EN.
import mc_pkg::*;

module mc_ctrl_fsm #(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       illegal,
  output logic       mem_err,
  output logic [3:0] dbg_state
);

  state_t            state;
  state_t            nxt;
  ctrl_t             ctrl_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_state;
  logic              timeout;
  logic              illegal_op;

  assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign timeout   = (MAX_WAIT != 0) && mem_state && !mem_ready &&
                     (wait_cnt == WAIT_W'(MAX_WAIT));

  always_comb begin
    nxt        = state;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXECR;
          OP_I:         nxt = S_EXECI;
          OP_BEQ:       nxt = S_BEQ;
`ifdef MC_CTRL_JAL_EN
          OP_JAL:       nxt = S_JAL;
`else
          OP_JAL:       begin nxt = S_TRAP; illegal_op = 1'b1; end
`endif
          default:      begin nxt = S_TRAP; illegal_op = 1'b1; end
        endcase
      end
      S_MEMADR:   nxt = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) nxt = S_MEMWB;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: if (mem_ready) nxt = S_FETCH;
      S_EXECR, S_EXECI: nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_BEQ:      nxt = S_FETCH;
`ifdef MC_CTRL_JAL_EN
      S_JAL:      nxt = S_ALUWB;
`endif
      default:    nxt = S_TRAP;
    endcase
    // timeout only fires with mem_ready low, so a same-cycle completion wins
    if (timeout) nxt = S_TRAP;
  end

  // control word is registered alongside the state it belongs to
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      ctrl_q   <= state_ctrl(S_FETCH);
      wait_cnt <= '0;
      illegal  <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      state  <= nxt;
      ctrl_q <= state_ctrl(nxt);
      if (nxt != state)
        wait_cnt <= '0;
      else if (mem_state && !mem_ready && (wait_cnt != '1))
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (illegal_op) illegal <= 1'b1;
      if (timeout)    mem_err <= 1'b1;
    end
  end

  assign IRWrite   = rst_n & ctrl_q.fetch & mem_ready;
  assign PCWrite   = rst_n & ((ctrl_q.fetch & mem_ready) | ctrl_q.pc_update |
                              (ctrl_q.branch & zero));
  assign MemWrite  = rst_n & ctrl_q.mem_write;
  assign RegWrite  = rst_n & ctrl_q.reg_write;
  assign AdrSrc    = ctrl_q.adr_src;
  assign ResultSrc = ctrl_q.result_src;
  assign ALUSrcA   = ctrl_q.src_a;
  assign ALUSrcB   = ctrl_q.src_b;
  assign dbg_state = state;

  mc_alu_dec u_alu_dec (
    .alu_op      (ctrl_q.alu_op),
    .funct3      (funct3),
    .op_b5       (op[5]),
    .funct7_b5   (funct7_b5),
    .alu_control (ALUControl)
  );

  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
`ifdef MC_CTRL_JAL_EN
      OP_JAL:  ImmSrc = IMM_J;
`endif
      default: ImmSrc = IMM_I;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: instruction sequencing, ALU decode, wait states, traps, reset.
module tb_mc_ctrl_fsm;

  localparam int FE = 0, DE = 1, MA = 2, MR = 3, MWB = 4, MWR = 5;
  localparam int EXR = 6, EXI = 7, AWB = 8, BQ = 9, JL = 10, TR = 11;

  logic       clk, rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_b5, zero, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal, mem_err;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] dbg_state;

  int ntests = 0;
  int nfail  = 0;
  int rw_cnt = 0;
  int ir_cnt = 0;
  int rw0, ir0;

  mc_ctrl_fsm #(.WAIT_W(4), .MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_b5(funct7_b5),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .illegal(illegal), .mem_err(mem_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (RegWrite === 1'b1) rw_cnt++;
    if (IRWrite === 1'b1) ir_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] ins);
    op        = ins[6:0];
    funct3    = ins[14:12];
    funct7_b5 = ins[30];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] alu_ins [7];
  int          alu_st  [7];
  int          alu_ctl [7];

  initial begin
    clk = 0; rst_n = 0; op = '0; funct3 = '0; funct7_b5 = 0; zero = 0; mem_ready = 1;
    alu_ins = '{32'h409409B3, 32'h0084A933, 32'h40941933, 32'h00506093,
                32'h0FF0F093, 32'hC0000093, 32'h00940933};
    alu_st  = '{EXR, EXR, EXR, EXI, EXI, EXI, EXR};
    alu_ctl = '{1, 5, 0, 3, 2, 0, 0};

    // reset: state and sticky flags clear, enables forced low despite mem_ready
    tick; tick;
    chk("rst_state", 32'(dbg_state), FE);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_mem_err", 32'(mem_err), 0);
    chk("rst_irwrite_forced", 32'(IRWrite), 0);
    chk("rst_pcwrite_forced", 32'(PCWrite), 0);

    // add x18,x8,x9 with zero wait states
    rst_n = 1; set_instr(32'h00940933); #1;
    chk("add_fetch_irwrite", 32'(IRWrite), 1);
    chk("add_fetch_pcwrite", 32'(PCWrite), 1);
    chk("add_fetch_srcb", 32'(ALUSrcB), 2);
    chk("add_fetch_resultsrc", 32'(ResultSrc), 2);
    chk("add_fetch_adrsrc", 32'(AdrSrc), 0);
    tick;
    chk("add_decode_state", 32'(dbg_state), DE);
    chk("add_decode_srca", 32'(ALUSrcA), 1);
    chk("add_decode_srcb", 32'(ALUSrcB), 1);
    chk("add_decode_irwrite", 32'(IRWrite), 0);
    tick;
    chk("add_execr_state", 32'(dbg_state), EXR);
    chk("add_execr_aluctl", 32'(ALUControl), 0);
    chk("add_execr_srca", 32'(ALUSrcA), 2);
    chk("add_execr_srcb", 32'(ALUSrcB), 0);
    chk("add_execr_regwrite", 32'(RegWrite), 0);
    tick;
    chk("add_aluwb_state", 32'(dbg_state), AWB);
    chk("add_aluwb_regwrite", 32'(RegWrite), 1);
    chk("add_aluwb_resultsrc", 32'(ResultSrc), 0);
    tick;
    chk("add_back_to_fetch", 32'(dbg_state), FE);

    // ALU decode table: sub, slt, R funct3=001 with bit30, ori, andi, addi with imm[10], add
    for (int i = 0; i < 7; i++) begin
      set_instr(alu_ins[i]);
      tick; tick;
      chk($sformatf("alu%0d_state", i), 32'(dbg_state), alu_st[i]);
      chk($sformatf("alu%0d_aluctl", i), 32'(ALUControl), alu_ctl[i]);
      tick;
      chk($sformatf("alu%0d_regwrite", i), 32'(RegWrite), 1);
      tick;
      chk($sformatf("alu%0d_fetch", i), 32'(dbg_state), FE);
    end

    // lw with three not-ready cycles in MEMREAD: 8 cycles, one RegWrite pulse
    set_instr(32'hFFC4A303); rw0 = rw_cnt;
    tick;
    chk("lw_decode_immsrc", 32'(ImmSrc), 0);
    tick;
    chk("lw_memadr_state", 32'(dbg_state), MA);
    chk("lw_memadr_srca", 32'(ALUSrcA), 2);
    mem_ready = 0;
    tick;
    chk("lw_memread_state", 32'(dbg_state), MR);
    chk("lw_memread_adrsrc0", 32'(AdrSrc), 1);
    chk("lw_memread_regwrite", 32'(RegWrite), 0);
    tick;
    chk("lw_memread_adrsrc1", 32'(AdrSrc), 1);
    tick;
    chk("lw_memread_adrsrc2", 32'(AdrSrc), 1);
    tick;
    chk("lw_memread_still", 32'(dbg_state), MR);
    mem_ready = 1; #1;
    chk("lw_memread_adrsrc3", 32'(AdrSrc), 1);
    tick;
    chk("lw_memwb_state", 32'(dbg_state), MWB);
    chk("lw_memwb_resultsrc", 32'(ResultSrc), 1);
    chk("lw_memwb_regwrite", 32'(RegWrite), 1);
    tick;
    chk("lw_8cycle_fetch", 32'(dbg_state), FE);
    chk("lw_regwrite_pulses", 32'(rw_cnt - rw0), 1);

    // sw with one not-ready cycle in MEMWRITE
    set_instr(32'h0064A423);
    tick;
    chk("sw_decode_immsrc", 32'(ImmSrc), 1);
    tick; mem_ready = 0;
    tick;
    chk("sw_memwrite_state", 32'(dbg_state), MWR);
    chk("sw_memwrite_we", 32'(MemWrite), 1);
    chk("sw_memwrite_adrsrc", 32'(AdrSrc), 1);
    mem_ready = 1; #1;
    chk("sw_memwrite_we_held", 32'(MemWrite), 1);
    tick;
    chk("sw_back_to_fetch", 32'(dbg_state), FE);
    chk("sw_fetch_memwrite", 32'(MemWrite), 0);

    // beq: PCWrite follows zero in BEQ
    set_instr(32'h00420463);
    tick;
    chk("beq_decode_immsrc", 32'(ImmSrc), 2);
    tick;
    chk("beq_state", 32'(dbg_state), BQ);
    zero = 1; #1;
    chk("beq_taken_pcwrite", 32'(PCWrite), 1);
    chk("beq_aluctl_sub", 32'(ALUControl), 1);
    zero = 0; #1;
    chk("beq_not_taken_pcwrite", 32'(PCWrite), 0);
    tick;
    chk("beq_back_to_fetch", 32'(dbg_state), FE);

    // reset asserted in ALUWB: write suppressed, back to FETCH
    set_instr(32'h00940933);
    tick; tick; tick;
    chk("midrst_aluwb", 32'(dbg_state), AWB);
    rst_n = 0; #1;
    chk("midrst_regwrite_forced", 32'(RegWrite), 0);
    tick;
    chk("midrst_fetch", 32'(dbg_state), FE);
    rst_n = 1;

    // jal
    set_instr(32'h0000006F);
    tick; tick;
`ifdef MC_CTRL_JAL_EN
    chk("jal_state", 32'(dbg_state), JL);
    chk("jal_pcwrite", 32'(PCWrite), 1);
    chk("jal_immsrc", 32'(ImmSrc), 3);
    chk("jal_srca", 32'(ALUSrcA), 1);
    tick;
    chk("jal_aluwb", 32'(dbg_state), AWB);
    chk("jal_regwrite", 32'(RegWrite), 1);
    tick;
    chk("jal_fetch", 32'(dbg_state), FE);
`else
    chk("jal_disabled_trap", 32'(dbg_state), TR);
    chk("jal_disabled_illegal", 32'(illegal), 1);
    rst_n = 0; tick; rst_n = 1;
`endif

    // unsupported opcode: sticky trap with all enables low
    set_instr(32'h00000000);
    tick; tick;
    chk("ill_state", 32'(dbg_state), TR);
    chk("ill_flag", 32'(illegal), 1);
    chk("ill_mem_err", 32'(mem_err), 0);
    tick; tick;
    chk("ill_stays_trap", 32'(dbg_state), TR);
    chk("ill_irwrite", 32'(IRWrite), 0);
    chk("ill_pcwrite", 32'(PCWrite), 0);
    chk("ill_regwrite", 32'(RegWrite), 0);
    rst_n = 0; tick; rst_n = 1;
    chk("ill_reset_clears", 32'(illegal), 0);
    chk("ill_reset_state", 32'(dbg_state), FE);

    // ready arriving on the last allowed wait cycle completes the fetch
    set_instr(32'h00940933); mem_ready = 0;
    repeat (15) tick;
    chk("edge_still_fetch", 32'(dbg_state), FE);
    mem_ready = 1; #1;
    chk("edge_irwrite", 32'(IRWrite), 1);
    tick;
    chk("edge_ready_wins", 32'(dbg_state), DE);
    chk("edge_no_mem_err", 32'(mem_err), 0);
    tick; tick; tick;
    chk("edge_fetch", 32'(dbg_state), FE);

    // fetch timeout: TRAP after 16 not-ready cycles
    mem_ready = 0; ir0 = ir_cnt;
    repeat (15) tick;
    chk("to_15_still_fetch", 32'(dbg_state), FE);
    tick;
    chk("to_16_trap", 32'(dbg_state), TR);
    chk("to_mem_err", 32'(mem_err), 1);
    chk("to_illegal", 32'(illegal), 0);
    chk("to_irwrite_never", 32'(ir_cnt - ir0), 0);
    mem_ready = 1; tick;
    chk("to_trap_sticky", 32'(dbg_state), TR);
    chk("to_trap_irwrite", 32'(IRWrite), 0);
    rst_n = 0; tick;
    chk("to_reset_state", 32'(dbg_state), FE);
    chk("to_reset_mem_err", 32'(mem_err), 0);
    rst_n = 1;
    tick;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
